exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
Execute stage of the 5-stage ARM pipeline. It sits directly downstream of the ID/EXE pipeline register and consumes the control bits, operands and immediate fields decoded in ID.
- Generates the second ALU operand (Val2), runs the ALU and computes the branch target.
- Owns the 4-bit status register (NZCV) that feeds back to ID condition checking.
- Holds the EXE/MEM pipeline register internally.

Parameters:
- WIDTH, 32, datapath width (only 32 is supported).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- freeze  in  1  hold every register in this block (MEM stall)
- flush  in  1  insert a bubble into EXE/MEM
- PC_in  in  32  PC+4 of the instruction in EXE
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in  in  1 each  control from ID/EXE
- EXE_CMD  in  4  ALU operation
- Val_Rn  in  32  first operand
- Val_Rm  in  32  register operand / store data
- imm  in  1  immediate-form flag
- Shift_operand  in  12  instruction bits [11:0]
- Signed_imm_24  in  24  branch offset
- Dest_in  in  4  destination register
- SR  out  4  registered {N,Z,C,V}
- Branch_taken  out  1  combinational, equal to B_in
- Branch_Addr  out  32  combinational, PC_in + (sign-extended Signed_imm_24 << 2)
- WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered
- ALU_Res  out  32  registered
- Val_Rm_out  out  32  registered
- Dest  out  4  registered

Behaviour:
- Reset and clocking: rst is asynchronous and active-high; the block uses one clock, clk. On reset, all registered outputs and SR are 0.
- Latency: 1 cycle. Inputs sampled at edge N appear on the registered outputs after edge N.
- Val2 generation, in priority order:
  - MEM_R_EN_in|MEM_W_EN_in: zero-extend Shift_operand[11:0].
  - imm=1: {24'b0,Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
  - Otherwise: Val_Rm shifted by Shift_operand[11:7] using type Shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes Val_Rm unchanged for every type.
- EXE_CMD encoding:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-!C
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags unchanged.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry out of the 33-bit sum. For subtraction, C = NOT borrow (ARM convention). V = signed overflow.
  - Logical ops and MOV/MVN: C and V keep their current SR values.
- SR update: SR loads the new flags at the edge when S_in=1 and freeze=0. It does not depend on flush.
- EXE/MEM register:
  - freeze=1: every register holds, including SR. freeze has priority over flush.
  - flush=1 and freeze=0: WB_EN, MEM_R_EN and MEM_W_EN load 0. Data fields are don't-care (load ALU result normally).
  - Otherwise: load WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, the ALU result, Val_Rm and Dest_in.
- Branch: Branch_taken and Branch_Addr are combinational from the current inputs so IF can redirect in the same cycle. The address adds modulo 2^32 (wrap-around is silent). The EXE/MEM control bits for a branch are whatever ID supplied (WB_EN=0 from the control unit).
- Mid-operation reset: an asynchronous reset clears the registers immediately, regardless of freeze or flush.

Test Plan:
- Reset: assert rst mid-cycle with freeze=1 -> SR=0000, WB_EN=0, ALU_Res=0 immediately, before the next clk edge.
- Immediate rotate: EXE_CMD=0001, imm=1, Shift_operand=0x2FF, S_in=1 -> Val2=0xF000000F. The next cycle shows ALU_Res=0xF000000F and SR N=1, Z=0, C/V unchanged.
- Flags: ADD with Rn=0x7FFFFFFF, Val2=1, S=1 -> ALU_Res=0x80000000, SR=1001. SUB with Rn=5, Val2=5, S=1 -> ALU_Res=0, SR=0110. SBC with Rn=5, Rm=3, C=0 -> ALU_Res=1.
- Register shift and memory offset:
  - ASR with Rm=0x80000000, Shift_operand[11:7]=4, type 10 -> Val2=0xF8000000.
  - LDR with MEM_R_EN_in=1, Rn=0x100, Shift_operand=0x804 -> ALU_Res=0x904, MEM_R_EN=1.
- Freeze/flush: hold freeze=1 for 3 cycles while the inputs change -> outputs and SR stay constant. Then flush=1, freeze=0 with WB_EN_in=1 -> WB_EN=0, SR still updates if S_in=1. Then freeze=1 with flush=1 -> hold.
- Branch: B_in=1, PC_in=0x00000010, Signed_imm_24=0xFFFFFE -> Branch_taken=1, Branch_Addr=0x00000008 in the same cycle. Signed_imm_24=0x3FFFFF with PC_in=0xFFFFFFF0 -> 32-bit wrap gives 0x00FFFFEC.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: builds Val2, runs the ALU, computes the branch target and owns the NZCV status register.
// Latency: 1 cycle to the EXE/MEM register outputs; Branch_taken/Branch_Addr are combinational.
// Backpressure: freeze holds every register including SR (wins over flush); flush bubbles the EXE/MEM controls.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   freeze, flush                  hold all state / insert bubble into EXE/MEM
//   PC_in                          PC+4 of the instruction currently in EXE
//   WB_EN_in, MEM_R_EN_in,
//   MEM_W_EN_in, B_in, S_in        control bits from the ID/EXE register
//   EXE_CMD                        ALU operation select
//   Val_Rn, Val_Rm                 first operand, register operand / store data
//   imm, Shift_operand             immediate flag and instruction bits [11:0]
//   Signed_imm_24                  branch word offset
//   Dest_in                        destination register index
//   SR                             registered {N,Z,C,V}
//   Branch_taken, Branch_Addr      same-cycle branch redirect to IF
//   WB_EN, MEM_R_EN, MEM_W_EN,
//   ALU_Res, Val_Rm_out, Dest      EXE/MEM pipeline register outputs

module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [WIDTH-1:0] PC_in,
    input  logic             WB_EN_in,
    input  logic             MEM_R_EN_in,
    input  logic             MEM_W_EN_in,
    input  logic             B_in,
    input  logic             S_in,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] Val_Rn,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic             imm,
    input  logic [11:0]      Shift_operand,
    input  logic [23:0]      Signed_imm_24,
    input  logic [3:0]       Dest_in,
    output logic [3:0]       SR,
    output logic             Branch_taken,
    output logic [WIDTH-1:0] Branch_Addr,
    output logic             WB_EN,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic [WIDTH-1:0] ALU_Res,
    output logic [WIDTH-1:0] Val_Rm_out,
    output logic [3:0]       Dest
);

    // ALU command codes
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // ------------------------------------------------------------------
    // Branch target: word offset sign-extended, scaled by 4, wraps mod 2^WIDTH
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] branch_offset;

    assign branch_offset = {{(WIDTH-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    assign Branch_Addr   = PC_in + branch_offset;
    assign Branch_taken  = B_in;

    // ------------------------------------------------------------------
    // Val2 generation
    // ------------------------------------------------------------------
    logic [4:0]       sh_amt;
    logic [1:0]       sh_type;
    logic [WIDTH-1:0] reg_shifted;
    logic [4:0]       rot_amt;
    logic [WIDTH-1:0] imm_base;
    logic [WIDTH-1:0] imm_rotated;
    logic [WIDTH-1:0] val2;

    assign sh_amt   = Shift_operand[11:7];
    assign sh_type  = Shift_operand[6:5];
    assign rot_amt  = {Shift_operand[11:8], 1'b0};
    assign imm_base = {{(WIDTH-8){1'b0}}, Shift_operand[7:0]};

    // Rotates are built from two logical shifts. A left shift by the full
    // width yields zero, so an amount of 0 falls out as a pass-through.
    assign imm_rotated = (imm_base >> rot_amt)
                       | (imm_base << (6'd32 - {1'b0, rot_amt}));

    always_comb begin
        reg_shifted = Val_Rm;
        case (sh_type)
            2'b00: reg_shifted = Val_Rm << sh_amt;
            2'b01: reg_shifted = Val_Rm >> sh_amt;
            2'b10: reg_shifted = $signed(Val_Rm) >>> sh_amt;
            2'b11: reg_shifted = (Val_Rm >> sh_amt)
                               | (Val_Rm << (6'd32 - {1'b0, sh_amt}));
            default: reg_shifted = Val_Rm;
        endcase
    end

    // Memory ops use the raw 12-bit offset even when imm is also set
    always_comb begin
        if (MEM_R_EN_in || MEM_W_EN_in) begin
            val2 = {{(WIDTH-12){1'b0}}, Shift_operand};
        end else if (imm) begin
            val2 = imm_rotated;
        end else begin
            val2 = reg_shifted;
        end
    end

    // ------------------------------------------------------------------
    // ALU and flag generation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend;
    logic             carry_in;
    logic             is_arith;
    logic             is_logic;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    // Subtraction is Rn + ~Val2 + 1 (or + C for SBC), so the adder carry
    // is already the ARM "not borrow" and overflow uses the inverted addend.
    always_comb begin
        alu_res  = '0;
        sum      = '0;
        addend   = val2;
        carry_in = 1'b0;
        is_arith = 1'b0;
        is_logic = 1'b0;
        flag_n   = SR[3];
        flag_z   = SR[2];
        flag_c   = SR[1];
        flag_v   = SR[0];

        case (EXE_CMD)
            CMD_MOV: begin
                alu_res  = val2;
                is_logic = 1'b1;
            end
            CMD_MVN: begin
                alu_res  = ~val2;
                is_logic = 1'b1;
            end
            CMD_ADD: begin
                addend   = val2;
                carry_in = 1'b0;
                is_arith = 1'b1;
            end
            CMD_ADC: begin
                addend   = val2;
                carry_in = SR[1];
                is_arith = 1'b1;
            end
            CMD_SUB: begin
                addend   = ~val2;
                carry_in = 1'b1;
                is_arith = 1'b1;
            end
            CMD_SBC: begin
                addend   = ~val2;
                carry_in = SR[1];
                is_arith = 1'b1;
            end
            CMD_AND: begin
                alu_res  = Val_Rn & val2;
                is_logic = 1'b1;
            end
            CMD_ORR: begin
                alu_res  = Val_Rn | val2;
                is_logic = 1'b1;
            end
            CMD_EOR: begin
                alu_res  = Val_Rn ^ val2;
                is_logic = 1'b1;
            end
            default: begin
                // unknown command: zero result, all flags kept
                alu_res = '0;
            end
        endcase

        if (is_arith) begin
            sum     = {1'b0, Val_Rn} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};
            alu_res = sum[WIDTH-1:0];
            flag_c  = sum[WIDTH];
            flag_v  = (Val_Rn[WIDTH-1] == addend[WIDTH-1])
                   && (alu_res[WIDTH-1] != Val_Rn[WIDTH-1]);
        end

        if (is_arith || is_logic) begin
            flag_n = alu_res[WIDTH-1];
            flag_z = (alu_res == '0);
        end
    end

    // ------------------------------------------------------------------
    // Status register and EXE/MEM pipeline register
    // ------------------------------------------------------------------
    // SR follows S_in regardless of flush: the flagged instruction really
    // executed, only its write-back/memory side effects are squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SR         <= 4'b0000;
            WB_EN      <= 1'b0;
            MEM_R_EN   <= 1'b0;
            MEM_W_EN   <= 1'b0;
            ALU_Res    <= '0;
            Val_Rm_out <= '0;
            Dest       <= 4'd0;
        end else if (!freeze) begin
            if (S_in) begin
                SR <= {flag_n, flag_z, flag_c, flag_v};
            end
            WB_EN      <= WB_EN_in    & ~flush;
            MEM_R_EN   <= MEM_R_EN_in & ~flush;
            MEM_W_EN   <= MEM_W_EN_in & ~flush;
            ALU_Res    <= alu_res;
            Val_Rm_out <= Val_Rm;
            Dest       <= Dest_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [31:0] PC_in;
    logic        WB_EN_in;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic        B_in;
    logic        S_in;
    logic [3:0]  EXE_CMD;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest_in;
    logic [3:0]  SR;
    logic        Branch_taken;
    logic [31:0] Branch_Addr;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm_out;
    logic [3:0]  Dest;

    int errors = 0;
    int checks = 0;

    exe_stage #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .flush         (flush),
        .PC_in         (PC_in),
        .WB_EN_in      (WB_EN_in),
        .MEM_R_EN_in   (MEM_R_EN_in),
        .MEM_W_EN_in   (MEM_W_EN_in),
        .B_in          (B_in),
        .S_in          (S_in),
        .EXE_CMD       (EXE_CMD),
        .Val_Rn        (Val_Rn),
        .Val_Rm        (Val_Rm),
        .imm           (imm),
        .Shift_operand (Shift_operand),
        .Signed_imm_24 (Signed_imm_24),
        .Dest_in       (Dest_in),
        .SR            (SR),
        .Branch_taken  (Branch_taken),
        .Branch_Addr   (Branch_Addr),
        .WB_EN         (WB_EN),
        .MEM_R_EN      (MEM_R_EN),
        .MEM_W_EN      (MEM_W_EN),
        .ALU_Res       (ALU_Res),
        .Val_Rm_out    (Val_Rm_out),
        .Dest          (Dest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic im, input logic [11:0] so, input logic s);
        EXE_CMD       = cmd;
        Val_Rn        = rn;
        Val_Rm        = rm;
        imm           = im;
        Shift_operand = so;
        S_in          = s;
    endtask

    task automatic ctrl(input logic wb, input logic mr, input logic mw, input logic [3:0] d);
        WB_EN_in    = wb;
        MEM_R_EN_in = mr;
        MEM_W_EN_in = mw;
        Dest_in     = d;
    endtask

    // sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        freeze = 1'b0;
        flush = 1'b0;
        PC_in = 32'h0;
        B_in = 1'b0;
        Signed_imm_24 = 24'h0;
        drive(4'h0, 32'h0, 32'h0, 1'b0, 12'h0, 1'b0);
        ctrl(1'b0, 1'b0, 1'b0, 4'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_sr",    32'(SR),      32'h0);
        chk("reset_wb",    32'(WB_EN),   32'h0);
        chk("reset_alu",   ALU_Res,      32'h0);
        chk("reset_memr",  32'(MEM_R_EN), 32'h0);
        chk("reset_dest",  32'(Dest),    32'h0);
        rst = 1'b0;

        // SUB 5-5 -> 0, Z and C (no borrow)
        drive(4'b0100, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1);
        ctrl(1'b1, 1'b0, 1'b0, 4'd1);
        tick();
        chk("sub_res",  ALU_Res, 32'h0);
        chk("sub_sr",   32'(SR), 32'h6);
        chk("sub_wb",   32'(WB_EN), 32'h1);
        chk("sub_dest", 32'(Dest), 32'h1);

        // MOV imm 0x2FF: 0xFF ror 4; C=1,V=0 kept
        drive(4'b0001, 32'h0, 32'h0, 1'b1, 12'h2FF, 1'b1);
        ctrl(1'b1, 1'b0, 1'b0, 4'd3);
        tick();
        chk("movimm_res", ALU_Res, 32'hF000000F);
        chk("movimm_sr",  32'(SR), 32'hA);

        // ADD overflow
        drive(4'b0010, 32'h7FFFFFFF, 32'h1, 1'b0, 12'h000, 1'b1);
        tick();
        chk("add_ovf_res", ALU_Res, 32'h80000000);
        chk("add_ovf_sr",  32'(SR), 32'h9);

        // ADD 1+1 clears flags
        drive(4'b0010, 32'h1, 32'h1, 1'b0, 12'h000, 1'b1);
        tick();
        chk("add_res", ALU_Res, 32'h2);
        chk("add_sr",  32'(SR), 32'h0);

        // SBC with C=0: 5-3-1
        drive(4'b0101, 32'd5, 32'd3, 1'b0, 12'h000, 1'b1);
        tick();
        chk("sbc_res", ALU_Res, 32'h1);
        chk("sbc_sr",  32'(SR), 32'h2);

        // ADC with C=1: 0xFFFFFFFF+0+1 wraps to 0 with carry
        drive(4'b0011, 32'hFFFFFFFF, 32'h0, 1'b0, 12'h000, 1'b1);
        tick();
        chk("adc_res", ALU_Res, 32'h0);
        chk("adc_sr",  32'(SR), 32'h6);

        // register shifts through MOV, S=0 keeps SR
        drive(4'b0001, 32'h0, 32'h80000000, 1'b0, 12'h240, 1'b0);
        tick();
        chk("asr4",     ALU_Res, 32'hF8000000);
        chk("asr_sr",   32'(SR), 32'h6);
        drive(4'b0001, 32'h0, 32'h80000000, 1'b0, 12'h220, 1'b0);
        tick();
        chk("lsr4", ALU_Res, 32'h08000000);
        drive(4'b0001, 32'h0, 32'h0000000F, 1'b0, 12'h260, 1'b0);
        tick();
        chk("ror4", ALU_Res, 32'hF0000000);
        drive(4'b0001, 32'h0, 32'h0000000F, 1'b0, 12'h200, 1'b0);
        tick();
        chk("lsl4", ALU_Res, 32'h000000F0);
        drive(4'b0001, 32'h0, 32'h12345678, 1'b0, 12'h060, 1'b0);
        tick();
        chk("ror0", ALU_Res, 32'h12345678);
        drive(4'b0001, 32'h0, 32'h87654321, 1'b0, 12'h040, 1'b0);
        tick();
        chk("asr0", ALU_Res, 32'h87654321);

        // logic ops; AND with S=1 keeps C=1,V=0
        drive(4'b0110, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 12'h000, 1'b1);
        tick();
        chk("and_res", ALU_Res, 32'h0F000F00);
        chk("and_sr",  32'(SR), 32'h2);
        drive(4'b0111, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 12'h000, 1'b0);
        tick();
        chk("orr_res", ALU_Res, 32'hFF0FFF0F);
        drive(4'b1000, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 12'h000, 1'b0);
        tick();
        chk("eor_res", ALU_Res, 32'hF00FF00F);
        drive(4'b1001, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        tick();
        chk("mvn_res", ALU_Res, 32'hFFFFFFFF);

        // unknown command: result 0, flags unchanged even with S=1
        drive(4'b1111, 32'h5, 32'h7, 1'b0, 12'h000, 1'b1);
        tick();
        chk("bad_res", ALU_Res, 32'h0);
        chk("bad_sr",  32'(SR), 32'h2);

        // LDR: memory offset beats imm rotate
        drive(4'b0010, 32'h100, 32'hDEADBEEF, 1'b1, 12'h804, 1'b0);
        ctrl(1'b1, 1'b1, 1'b0, 4'd4);
        tick();
        chk("ldr_res",  ALU_Res, 32'h904);
        chk("ldr_memr", 32'(MEM_R_EN), 32'h1);
        chk("ldr_memw", 32'(MEM_W_EN), 32'h0);

        // STR
        drive(4'b0010, 32'h200, 32'hCAFEF00D, 1'b0, 12'h010, 1'b0);
        ctrl(1'b0, 1'b0, 1'b1, 4'd5);
        tick();
        chk("str_res",  ALU_Res, 32'h210);
        chk("str_memw", 32'(MEM_W_EN), 32'h1);
        chk("str_rm",   Val_Rm_out, 32'hCAFEF00D);
        chk("str_wb",   32'(WB_EN), 32'h0);

        // freeze for 3 cycles with changing inputs
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 32'(i + 1), 32'h10, 1'b0, 12'h000, 1'b1);
            ctrl(1'b1, 1'b0, 1'b0, 4'(9 + i));
            tick();
            chk("frz_res",  ALU_Res, 32'h210);
            chk("frz_sr",   32'(SR), 32'h2);
            chk("frz_memw", 32'(MEM_W_EN), 32'h1);
            chk("frz_dest", 32'(Dest), 32'h5);
        end

        // flush: controls squashed, SR still updates
        freeze = 1'b0;
        flush = 1'b1;
        drive(4'b0010, 32'h1, 32'h1, 1'b0, 12'h000, 1'b1);
        ctrl(1'b1, 1'b0, 1'b1, 4'd6);
        tick();
        chk("flush_wb",   32'(WB_EN), 32'h0);
        chk("flush_memw", 32'(MEM_W_EN), 32'h0);
        chk("flush_sr",   32'(SR), 32'h0);

        // normal cycle to load distinguishable state
        flush = 1'b0;
        drive(4'b0010, 32'hFFFFFFFF, 32'h8, 1'b0, 12'h000, 1'b1);
        ctrl(1'b1, 1'b0, 1'b0, 4'd7);
        tick();
        chk("load_res", ALU_Res, 32'h7);
        chk("load_sr",  32'(SR), 32'h2);
        chk("load_wb",  32'(WB_EN), 32'h1);

        // freeze beats flush
        freeze = 1'b1;
        flush = 1'b1;
        drive(4'b0100, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1);
        ctrl(1'b1, 1'b0, 1'b0, 4'd2);
        tick();
        chk("frzfl_wb",   32'(WB_EN), 32'h1);
        chk("frzfl_res",  ALU_Res, 32'h7);
        chk("frzfl_sr",   32'(SR), 32'h2);
        chk("frzfl_dest", 32'(Dest), 32'h7);

        // branch target, combinational
        B_in = 1'b1;
        PC_in = 32'h00000010;
        Signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("br_taken", 32'(Branch_taken), 32'h1);
        chk("br_back",  Branch_Addr, 32'h00000008);
        PC_in = 32'hFFFFFFF0;
        Signed_imm_24 = 24'h3FFFFF;
        #1;
        chk("br_wrap", Branch_Addr, 32'h00FFFFEC);
        B_in = 1'b0;
        #1;
        chk("br_not", 32'(Branch_taken), 32'h0);

        // asynchronous reset mid-cycle while frozen
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sr",  32'(SR), 32'h0);
        chk("arst_wb",  32'(WB_EN), 32'h0);
        chk("arst_res", ALU_Res, 32'h0);
        chk("arst_rm",  Val_Rm_out, 32'h0);
        tick();
        rst = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
